// File: rtl/vga_sync_gen_pkg.sv
// Default 640x480@60 timing (50 MHz system clock, 25 MHz pixel rate) shared by RTL and bench.
package vga_sync_gen_pkg;

  localparam int DEF_CLK_DIV = 2;

  localparam int DEF_H_PW  = 96;
  localparam int DEF_H_BP  = 48;
  localparam int DEF_H_VIS = 640;
  localparam int DEF_H_FP  = 16;

  localparam int DEF_V_PW  = 2;
  localparam int DEF_V_BP  = 29;
  localparam int DEF_V_VIS = 480;
  localparam int DEF_V_FP  = 10;

  function automatic int axis_total(int pw, int bp, int vis, int fp);
    return pw + bp + vis + fp;
  endfunction

  localparam int DEF_H_TOTAL = axis_total(DEF_H_PW, DEF_H_BP, DEF_H_VIS, DEF_H_FP);
  localparam int DEF_V_TOTAL = axis_total(DEF_V_PW, DEF_V_BP, DEF_V_VIS, DEF_V_FP);

endpackage

// File: rtl/vga_sync_gen_counter.sv
// One timing axis: 10-bit position counter with origin at the start of the sync pulse.
module vga_sync_gen_counter
  import vga_sync_gen_pkg::*;
#(
  parameter int PW  = DEF_H_PW,
  parameter int BP  = DEF_H_BP,
  parameter int VIS = DEF_H_VIS,
  parameter int FP  = DEF_H_FP
) (
  input  logic       i_clk,
  input  logic       i_rst,
  input  logic       i_en,
  output logic [9:0] o_cnt,
  output logic       o_wrap,
  output logic       o_in_pw_nxt,
  output logic       o_in_vis
);

  localparam int         TOTAL  = axis_total(PW, BP, VIS, FP);
  localparam logic [9:0] LAST   = 10'(TOTAL - 1);
  localparam logic [9:0] PW_END = 10'(PW);
  localparam logic [9:0] VIS_LO = 10'(PW + BP);
  localparam logic [9:0] VIS_HI = 10'(PW + BP + VIS);

  logic [9:0] r_cnt;
  logic       w_wrap;

  assign w_wrap = (r_cnt == LAST);

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst)     r_cnt <= LAST;
    else if (i_en) r_cnt <= w_wrap ? 10'd0 : r_cnt + 10'd1;
  end

  // Sync phase of the position the counter holds after this clock edge.
  assign o_in_pw_nxt = i_en ? (w_wrap || ((r_cnt + 10'd1) < PW_END)) : (r_cnt < PW_END);

  assign o_cnt    = r_cnt;
  assign o_wrap   = w_wrap;
  assign o_in_vis = (r_cnt >= VIS_LO) && (r_cnt < VIS_HI);

endmodule

// File: rtl/vga_sync_gen.sv
// VGA timing generator: pixel divider, h/v counters, registered blanked RGB and active-low syncs.
module vga_sync_gen
  import vga_sync_gen_pkg::*;
#(
  parameter int CLK_DIV = DEF_CLK_DIV,
  parameter int H_PW    = DEF_H_PW,
  parameter int H_BP    = DEF_H_BP,
  parameter int H_VIS   = DEF_H_VIS,
  parameter int H_FP    = DEF_H_FP,
  parameter int V_PW    = DEF_V_PW,
  parameter int V_BP    = DEF_V_BP,
  parameter int V_VIS   = DEF_V_VIS,
  parameter int V_FP    = DEF_V_FP
) (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic [11:0] i_rgb_in,
  output logic [9:0]  o_x,
  output logic [9:0]  o_y,
  output logic        o_active,
  output logic        o_pix_tick,
  output logic        o_frame_start,
  output logic [3:0]  o_vga_r,
  output logic [3:0]  o_vga_g,
  output logic [3:0]  o_vga_b,
  output logic        o_vga_hsync,
  output logic        o_vga_vsync,
  output logic        o_synchronized
);

  localparam int               DIV_W    = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);
  localparam logic [9:0]       H_VIS_LO = 10'(H_PW + H_BP);
  localparam logic [9:0]       V_VIS_LO = 10'(V_PW + V_BP);

  logic [DIV_W-1:0] r_div;
  logic             w_tick;
  logic [9:0]       w_h_cnt, w_v_cnt;
  logic             w_h_wrap, w_v_wrap;
  logic             w_h_pw_nxt, w_v_pw_nxt;
  logic             w_h_vis, w_v_vis, w_active;
  logic             w_frame_edge;

  logic             r_hsync, r_vsync, r_frame_start, r_sync;
  logic [11:0]      r_rgb;

  assign w_tick = (r_div == DIV_LAST);

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) r_div <= '0;
    else       r_div <= w_tick ? '0 : r_div + 1'b1;
  end

  vga_sync_gen_counter #(.PW(H_PW), .BP(H_BP), .VIS(H_VIS), .FP(H_FP)) u_h_cnt (
    .i_clk       (i_clk),
    .i_rst       (i_rst),
    .i_en        (w_tick),
    .o_cnt       (w_h_cnt),
    .o_wrap      (w_h_wrap),
    .o_in_pw_nxt (w_h_pw_nxt),
    .o_in_vis    (w_h_vis)
  );

  vga_sync_gen_counter #(.PW(V_PW), .BP(V_BP), .VIS(V_VIS), .FP(V_FP)) u_v_cnt (
    .i_clk       (i_clk),
    .i_rst       (i_rst),
    .i_en        (w_tick & w_h_wrap),
    .o_cnt       (w_v_cnt),
    .o_wrap      (w_v_wrap),
    .o_in_pw_nxt (w_v_pw_nxt),
    .o_in_vis    (w_v_vis)
  );

  assign w_active = w_h_vis & w_v_vis;
  assign o_active = w_active;
  assign o_x      = w_active ? (w_h_cnt - H_VIS_LO) : 10'd0;
  assign o_y      = w_active ? (w_v_cnt - V_VIS_LO) : 10'd0;

  // Both counters wrapping to the origin is exactly when vsync enters its pulse.
  assign w_frame_edge = w_tick & w_h_wrap & w_v_wrap;

  // Syncs track the counters' new position; RGB is the pixel requested during the tick just ending.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_hsync       <= 1'b1;
      r_vsync       <= 1'b1;
      r_rgb         <= 12'h000;
      r_frame_start <= 1'b0;
      r_sync        <= 1'b0;
    end else begin
      r_frame_start <= w_frame_edge;
      if (w_frame_edge) r_sync <= 1'b1;
      if (w_tick) begin
        r_hsync <= ~w_h_pw_nxt;
        r_vsync <= ~w_v_pw_nxt;
        r_rgb   <= w_active ? i_rgb_in : 12'h000;
      end
    end
  end

  assign o_pix_tick     = w_tick;
  assign o_frame_start  = r_frame_start;
  assign o_synchronized = r_sync;
  assign o_vga_hsync    = r_hsync;
  assign o_vga_vsync    = r_vsync;
  assign o_vga_r        = r_rgb[11:8];
  assign o_vga_g        = r_rgb[7:4];
  assign o_vga_b        = r_rgb[3:0];

endmodule

// File: tb/tb_vga_sync_gen.sv
// Directed bench: default-timing instance for line timing, shrunken-timing instance for whole frames.
module tb_vga_sync_gen;
  import vga_sync_gen_pkg::*;

  localparam int S_DIV = 3;
  localparam int S_HPW = 3, S_HBP = 2, S_HVIS = 6, S_HFP = 2;
  localparam int S_VPW = 2, S_VBP = 2, S_VVIS = 4, S_VFP = 1;
  localparam int S_HT  = 13;
  localparam int S_VT  = 9;
  localparam int S_FT  = S_HT * S_VT;

  logic clk = 1'b0;
  always #10 clk = ~clk;

  int total = 0;
  int bad   = 0;

  logic        d_rst, d_active, d_tick, d_fs, d_hs, d_vs, d_sync;
  logic [11:0] d_rgb_in;
  logic [9:0]  d_x, d_y;
  logic [3:0]  d_r, d_g, d_b;

  logic        s_rst, s_active, s_tick, s_fs, s_hs, s_vs, s_sync;
  logic [11:0] s_rgb_in;
  logic [9:0]  s_x, s_y;
  logic [3:0]  s_r, s_g, s_b;

  vga_sync_gen dut (
    .i_clk(clk), .i_rst(d_rst), .i_rgb_in(d_rgb_in),
    .o_x(d_x), .o_y(d_y), .o_active(d_active), .o_pix_tick(d_tick), .o_frame_start(d_fs),
    .o_vga_r(d_r), .o_vga_g(d_g), .o_vga_b(d_b),
    .o_vga_hsync(d_hs), .o_vga_vsync(d_vs), .o_synchronized(d_sync)
  );

  vga_sync_gen #(
    .CLK_DIV(S_DIV), .H_PW(S_HPW), .H_BP(S_HBP), .H_VIS(S_HVIS), .H_FP(S_HFP),
    .V_PW(S_VPW), .V_BP(S_VBP), .V_VIS(S_VVIS), .V_FP(S_VFP)
  ) sdut (
    .i_clk(clk), .i_rst(s_rst), .i_rgb_in(s_rgb_in),
    .o_x(s_x), .o_y(s_y), .o_active(s_active), .o_pix_tick(s_tick), .o_frame_start(s_fs),
    .o_vga_r(s_r), .o_vga_g(s_g), .o_vga_b(s_b),
    .o_vga_hsync(s_hs), .o_vga_vsync(s_vs), .o_synchronized(s_sync)
  );

  // Upstream pixel source: colour encodes the requested coordinate.
  assign s_rgb_in = {s_x[3:0], s_y[3:0], 4'hA};

  task automatic test_reset();
    d_rst = 1'b1; s_rst = 1'b1; d_rgb_in = 12'hFFF;
    repeat (3) @(negedge clk);
    total++; if ({d_hs, d_vs} !== 2'b11) begin bad++; $display("FAIL reset_syncs got=%b exp=11", {d_hs, d_vs}); end
    total++; if ({d_r, d_g, d_b} !== 12'h000) begin bad++; $display("FAIL reset_rgb got=%h exp=000", {d_r, d_g, d_b}); end
    total++; if ({d_sync, d_fs, d_tick} !== 3'b000) begin bad++; $display("FAIL reset_flags got=%b exp=000", {d_sync, d_fs, d_tick}); end
    total++; if ({d_active, d_x, d_y} !== 21'd0) begin bad++; $display("FAIL reset_pos got=%b/%0d/%0d exp=0/0/0", d_active, d_x, d_y); end
    total++;
    if ({s_hs, s_vs, s_r, s_g, s_b, s_sync, s_fs, s_tick, s_active} !== {2'b11, 12'h000, 4'b0000}) begin
      bad++; $display("FAIL reset_small got=%b", {s_hs, s_vs, s_r, s_g, s_b, s_sync, s_fs, s_tick, s_active});
    end
  endtask

  task automatic test_first_sync();
    int n;
    @(negedge clk);
    d_rst = 1'b0;
    n = 0;
    while (d_hs !== 1'b0 && n < 10) begin @(negedge clk); n++; end
    total++; if (n !== 2) begin bad++; $display("FAIL first_hsync_clks got=%0d exp=2", n); end
    total++; if ({d_vs, d_fs, d_sync} !== 3'b011) begin bad++; $display("FAIL first_frame got=%b exp=011", {d_vs, d_fs, d_sync}); end
    @(negedge clk);
    total++; if ({d_fs, d_sync} !== 2'b01) begin bad++; $display("FAIL frame_start_width got=%b exp=01", {d_fs, d_sync}); end
  endtask

  task automatic test_hsync_timing();
    int n, hi, lo;
    logic seen;
    seen = 1'b0;
    n = 0;
    while (d_hs !== 1'b1 && n < 2000) begin @(negedge clk); n++; end
    total++; if (n !== 191) begin bad++; $display("FAIL hsync_first_rise got=%0d exp=191", n); end
    for (int ln = 0; ln < 3; ln++) begin
      hi = 0;
      while (d_hs === 1'b1 && hi < 2000) begin
        @(negedge clk); hi++;
        if ({d_r, d_g, d_b} != 12'h000 || d_active) seen = 1'b1;
      end
      lo = 0;
      while (d_hs === 1'b0 && lo < 2000) begin
        @(negedge clk); lo++;
        if ({d_r, d_g, d_b} != 12'h000 || d_active) seen = 1'b1;
      end
      total++; if (lo !== 192) begin bad++; $display("FAIL hsync_low line=%0d got=%0d exp=192", ln, lo); end
      total++; if (hi + lo !== 1600) begin bad++; $display("FAIL hsync_period line=%0d got=%0d exp=1600", ln, hi + lo); end
    end
    total++; if (seen !== 1'b0) begin bad++; $display("FAIL vporch_blank got=%b exp=0", seen); end
  endtask

  task automatic test_default_mid_reset();
    int n;
    n = 0;
    while (d_hs !== 1'b0 && n < 2000) begin @(negedge clk); n++; end
    total++; if (d_hs !== 1'b0) begin bad++; $display("FAIL mid_reset_pre got=%b exp=0", d_hs); end
    #2 d_rst = 1'b1;
    #1;
    total++; if ({d_hs, d_vs, d_sync, d_r, d_g, d_b} !== {3'b110, 12'h000}) begin
      bad++; $display("FAIL mid_reset_async got=%b exp=110_000000000000", {d_hs, d_vs, d_sync, d_r, d_g, d_b});
    end
  endtask

  task automatic test_small_frames();
    int n, kk, hh, vv, j, hj, vj, fs_cnt;
    logic hs_e, vs_e, act_e;
    logic [11:0] rgb_e;
    logic [9:0] x_e, y_e;
    fs_cnt = 0;
    @(negedge clk);
    s_rst = 1'b0;
    n = 0;
    while (s_vs !== 1'b0 && n < 20) begin @(negedge clk); n++; end
    total++; if (n !== 3) begin bad++; $display("FAIL small_first_vsync got=%0d exp=3", n); end
    for (int k = 0; k < 3 * S_FT; k++) begin
      kk = k % S_FT; hh = kk % S_HT; vv = kk / S_HT;
      hs_e = !(hh < S_HPW);
      vs_e = !(vv < S_VPW);
      j = (kk + S_FT - 1) % S_FT; hj = j % S_HT; vj = j / S_HT;
      if (hj >= S_HPW + S_HBP && hj < S_HPW + S_HBP + S_HVIS && vj >= S_VPW + S_VBP && vj < S_VPW + S_VBP + S_VVIS)
        rgb_e = {4'(hj - S_HPW - S_HBP), 4'(vj - S_VPW - S_VBP), 4'hA};
      else
        rgb_e = 12'h000;
      act_e = (hh >= S_HPW + S_HBP && hh < S_HPW + S_HBP + S_HVIS && vv >= S_VPW + S_VBP && vv < S_VPW + S_VBP + S_VVIS);
      x_e = act_e ? 10'(hh - S_HPW - S_HBP) : 10'd0;
      y_e = act_e ? 10'(vv - S_VPW - S_VBP) : 10'd0;
      if (s_fs === 1'b1) fs_cnt++;
      total++;
      if ({s_hs, s_vs, s_r, s_g, s_b} !== {hs_e, vs_e, rgb_e}) begin
        bad++; $display("FAIL pins tick=%0d got=%b%b_%h exp=%b%b_%h", k, s_hs, s_vs, {s_r, s_g, s_b}, hs_e, vs_e, rgb_e);
      end
      total++;
      if ({s_active, s_x, s_y} !== {act_e, x_e, y_e}) begin
        bad++; $display("FAIL position tick=%0d got=%b/%0d/%0d exp=%b/%0d/%0d", k, s_active, s_x, s_y, act_e, x_e, y_e);
      end
      total++;
      if ({s_fs, s_tick, s_sync} !== {(kk == 0), 1'b0, 1'b1}) begin
        bad++; $display("FAIL flags tick=%0d got=%b exp=%b", k, {s_fs, s_tick, s_sync}, {(kk == 0), 2'b01});
      end
      repeat (S_DIV) @(negedge clk);
    end
    total++; if (fs_cnt !== 3) begin bad++; $display("FAIL frame_start_count got=%0d exp=3", fs_cnt); end
  endtask

  task automatic test_small_mid_reset_active();
    repeat (72 * S_DIV) @(negedge clk);
    total++; if ({s_hs, s_vs, s_r, s_g, s_b} !== {2'b11, 12'h11A}) begin
      bad++; $display("FAIL active_pre got=%b%b_%h exp=11_11a", s_hs, s_vs, {s_r, s_g, s_b});
    end
    #2 s_rst = 1'b1;
    #1;
    total++; if ({s_hs, s_vs, s_sync, s_active, s_r, s_g, s_b} !== {4'b1100, 12'h000}) begin
      bad++; $display("FAIL active_reset got=%b exp=1100_000000000000", {s_hs, s_vs, s_sync, s_active, s_r, s_g, s_b});
    end
  endtask

  task automatic test_small_restart();
    int n;
    @(negedge clk);
    s_rst = 1'b0;
    n = 0;
    while (s_vs !== 1'b0 && n < 20) begin @(negedge clk); n++; end
    total++; if (n !== 3) begin bad++; $display("FAIL restart_clks got=%0d exp=3", n); end
    total++; if ({s_hs, s_fs, s_sync} !== 3'b011) begin bad++; $display("FAIL restart_frame got=%b exp=011", {s_hs, s_fs, s_sync}); end
    repeat (14 * S_DIV) @(negedge clk);
    total++; if ({s_hs, s_vs} !== 2'b00) begin bad++; $display("FAIL in_pulse_pre got=%b exp=00", {s_hs, s_vs}); end
    #2 s_rst = 1'b1;
    #1;
    total++; if ({s_hs, s_vs, s_sync} !== 3'b110) begin bad++; $display("FAIL in_pulse_reset got=%b exp=110", {s_hs, s_vs, s_sync}); end
  endtask

  initial begin
    test_reset();
    test_first_sync();
    test_hsync_timing();
    test_default_mid_reset();
    test_first_sync();
    test_small_frames();
    test_small_mid_reset_active();
    test_small_restart();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
